// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 (7,5 octal) convolutional encoder and a hard-decision
// 4-state Viterbi decoder with register-exchange survivors.
// The two halves share only clk and rst.
module viterbi_codec #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_enable_i,
   input  logic       enc_d_in,
   output logic       enc_valid_o,
   output logic [1:0] enc_d_out,
   input  logic       dec_enable,
   input  logic [1:0] dec_d_in,
   output logic       dec_d_out,
   output logic       dec_valid_o
);

   localparam int PM_MAX  = (1 << PM_W) - 1;
   // Non-zero start states get a large metric so decoding starts from state 00.
   localparam int PM_INIT = (2 * TB_DEPTH > PM_MAX) ? PM_MAX : 2 * TB_DEPTH;
   localparam int CNT_W   = $clog2(TB_DEPTH);

   // ---------------------------------------------------------------- encoder
   logic [1:0] enc_s;   // {s1,s0}, s0 = most recent accepted bit

   // Shift the accepted bit into the encoder state and register the symbol.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_s       <= 2'b00;
         enc_d_out   <= 2'b00;
         enc_valid_o <= 1'b0;
      end else begin
         enc_valid_o <= enc_enable_i;
         if (enc_enable_i) begin
            enc_d_out <= {enc_d_in ^ enc_s[0] ^ enc_s[1], enc_d_in ^ enc_s[1]};
            enc_s     <= {enc_s[0], enc_d_in};
         end
      end
   end

   // ---------------------------------------------------------------- decoder
   logic [PM_W-1:0]     pm      [4];
   logic [TB_DEPTH-1:0] sv      [4];
   logic [CNT_W-1:0]    fill_cnt;   // symbols left before the survivors are full

   logic [PM_W:0]       cand0   [4];
   logic [PM_W:0]       cand1   [4];
   logic [PM_W:0]       pm_raw  [4];
   logic [PM_W:0]       pm_diff [4];
   logic [PM_W-1:0]     pm_next [4];
   logic [TB_DEPTH-1:0] sv_next [4];
   logic [PM_W:0]       pm_min;
   logic [1:0]          best;

   // Hamming distance between the received symbol and the branch label
   // for predecessor {a,b} taking input u.
   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic a,
                                                input logic b, input logic u);
      logic [1:0] d;
      d = rx ^ {u ^ b ^ a, u ^ a};
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

   // Add-compare-select for all four states, then normalise to the minimum.
   // Next state n = {b,u}; its predecessors are {0,b} (index b) and {1,b}.
   always_comb begin
      pm_min = '1;
      best   = 2'd0;
      for (int n = 0; n < 4; n++) begin
         cand0[n] = {1'b0, pm[n >> 1]} +
                    (PM_W+1)'(branch_metric(dec_d_in, 1'b0, 1'(n >> 1), 1'(n & 1)));
         cand1[n] = {1'b0, pm[(n >> 1) + 2]} +
                    (PM_W+1)'(branch_metric(dec_d_in, 1'b1, 1'(n >> 1), 1'(n & 1)));
         // ties keep the a=0 predecessor
         if (cand1[n] < cand0[n]) begin
            pm_raw[n]  = cand1[n];
            sv_next[n] = (sv[(n >> 1) + 2] << 1) | TB_DEPTH'(n & 1);
         end else begin
            pm_raw[n]  = cand0[n];
            sv_next[n] = (sv[n >> 1] << 1) | TB_DEPTH'(n & 1);
         end
         if (pm_raw[n] < pm_min) begin
            pm_min = pm_raw[n];
            best   = 2'(n);
         end
      end
      for (int n = 0; n < 4; n++) begin
         pm_diff[n] = pm_raw[n] - pm_min;
         pm_next[n] = (pm_diff[n] > (PM_W+1)'(PM_MAX)) ? PM_W'(PM_MAX)
                                                       : pm_diff[n][PM_W-1:0];
      end
   end

   // Commit metrics and survivors; emit the oldest bit of the best survivor.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 4; n++) begin
            pm[n] <= (n == 0) ? '0 : PM_W'(PM_INIT);
            sv[n] <= '0;
         end
         fill_cnt    <= CNT_W'(TB_DEPTH - 1);
         dec_d_out   <= 1'b0;
         dec_valid_o <= 1'b0;
      end else if (dec_enable) begin
         for (int n = 0; n < 4; n++) begin
            pm[n] <= pm_next[n];
            sv[n] <= sv_next[n];
         end
         dec_d_out <= sv_next[best][TB_DEPTH-1];
         if (!dec_valid_o) begin
            if (fill_cnt == '0) dec_valid_o <= 1'b1;
            else                fill_cnt    <= fill_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: encoder vector table plus random loopback
// streams checked against a bit-queue reference model.
module tb_viterbi_codec;

   localparam int TB_DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enc_enable_i = 1'b0;
   logic       enc_d_in = 1'b0;
   logic       enc_valid_o;
   logic [1:0] enc_d_out;
   logic       dec_enable = 1'b0;
   logic [1:0] dec_d_in = 2'b00;
   logic       dec_d_out;
   logic       dec_valid_o;

   int vectors = 0;
   int miscompares = 0;

   bit         data_q[$];   // every bit the encoder accepted since reset
   int         n_acc;       // symbols the decoder accepted since reset
   logic [1:0] exp_enc;
   logic       exp_eval;

   typedef struct {
      logic       en;
      logic       d;
      logic       exp_v;
      logic [1:0] exp_out;
   } enc_vec_t;

   enc_vec_t tbl[10];

   viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(6)) dut (
      .clk(clk),
      .rst(rst),
      .enc_enable_i(enc_enable_i),
      .enc_d_in(enc_d_in),
      .enc_valid_o(enc_valid_o),
      .enc_d_out(enc_d_out),
      .dec_enable(dec_enable),
      .dec_d_in(dec_d_in),
      .dec_d_out(dec_d_out),
      .dec_valid_o(dec_valid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Generator polynomials 7 and 5 applied to the window {u, u-1, u-2}.
   function automatic logic [1:0] conv_symbol(input bit u);
      int k;
      bit m1, m2;
      logic [2:0] w;
      k  = data_q.size();
      m1 = (k >= 1) ? data_q[k-1] : 1'b0;
      m2 = (k >= 2) ? data_q[k-2] : 1'b0;
      w  = {u, m1, m2};
      return {^(w & 3'b111), ^(w & 3'b101)};
   endfunction

   function automatic logic [1:0] channel_err(input int mode, input int idx);
      if (mode == 1 && (idx % 16) == 5) return 2'b01;
      if (mode == 2 && ((idx % 24) == 9 || (idx % 24) == 10)) return 2'b01;
      return 2'b00;
   endfunction

   // Pulse reset low for one cycle; outputs must clear without waiting for a clock.
   task automatic do_reset();
      rst = 1'b0;
      enc_enable_i = 1'b0;
      enc_d_in = 1'b0;
      dec_enable = 1'b0;
      dec_d_in = 2'b00;
      data_q.delete();
      n_acc = 0;
      exp_enc = 2'b00;
      exp_eval = 1'b0;
      #1;
      chk("rst_enc_valid", enc_valid_o, 0);
      chk("rst_enc_out", enc_d_out, 0);
      chk("rst_dec_valid", dec_valid_o, 0);
      chk("rst_dec_out", dec_d_out, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Random data through the reference encoder into the decoder, one cycle later.
   task automatic run_stream(input int ncyc, input int mode, input int rst_at);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         exp_eval = enc_enable_i;
         if (enc_enable_i) begin
            exp_enc = conv_symbol(enc_d_in);
            data_q.push_back(enc_d_in);
         end
         if (dec_enable) n_acc++;
         #1;
         chk("enc_valid", enc_valid_o, exp_eval);
         chk("enc_out", enc_d_out, exp_enc);
         chk("dec_valid", dec_valid_o, (n_acc >= TB_DEPTH));
         if (n_acc >= TB_DEPTH) chk("dec_out", dec_d_out, data_q[n_acc - TB_DEPTH]);
         if (c == rst_at) do_reset();
         dec_enable   = exp_eval;
         dec_d_in     = exp_enc ^ channel_err(mode, n_acc);
         enc_enable_i = ($urandom_range(0, 7) != 0);
         enc_d_in     = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 2'b11};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 2'b10};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 2'b00};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 2'b01};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 2'b01};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 2'b01};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 2'b01};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b10};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 2'b01};
      tbl[9] = '{1'b1, 1'b0, 1'b1, 2'b11};

      #2;
      do_reset();

      for (int i = 0; i < 10; i++) begin
         enc_enable_i = tbl[i].en;
         enc_d_in     = tbl[i].d;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), enc_valid_o, tbl[i].exp_v);
         chk($sformatf("tbl%0d_out", i), enc_d_out, tbl[i].exp_out);
      end

      do_reset();
      run_stream(320, 0, -1);
      do_reset();
      run_stream(320, 1, -1);
      do_reset();
      run_stream(320, 2, -1);
      do_reset();
      run_stream(320, 0, 150);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
